// File: rtl/tl_a_arbiter_2to1.sv
// Two-client to one-manager TileLink-UL arbiter: round-robin A grant with burst lock, D routed by source MSB.
// Optional TL_ARB_PERF_EN adds per-client grant counters and a conflict-cycle counter.
module tl_a_arbiter_2to1 #(
  parameter int SRC_W    = 5,
  parameter int ADDR_W   = 31,
  parameter int DATA_W   = 64,
  parameter int MAX_SIZE = 6
) (
  input  logic                clock,
  input  logic                reset,
`ifdef TL_ARB_PERF_EN
  output logic [31:0]         grant_cnt0,
  output logic [31:0]         grant_cnt1,
  output logic [31:0]         conflict_cnt,
`endif
  input  logic                in0_a_valid,
  output logic                in0_a_ready,
  input  logic [2:0]          in0_a_bits_opcode,
  input  logic [2:0]          in0_a_bits_param,
  input  logic [2:0]          in0_a_bits_size,
  input  logic [SRC_W-1:0]    in0_a_bits_source,
  input  logic [ADDR_W-1:0]   in0_a_bits_address,
  input  logic [DATA_W/8-1:0] in0_a_bits_mask,
  input  logic [DATA_W-1:0]   in0_a_bits_data,
  input  logic                in0_a_bits_corrupt,
  input  logic                in1_a_valid,
  output logic                in1_a_ready,
  input  logic [2:0]          in1_a_bits_opcode,
  input  logic [2:0]          in1_a_bits_param,
  input  logic [2:0]          in1_a_bits_size,
  input  logic [SRC_W-1:0]    in1_a_bits_source,
  input  logic [ADDR_W-1:0]   in1_a_bits_address,
  input  logic [DATA_W/8-1:0] in1_a_bits_mask,
  input  logic [DATA_W-1:0]   in1_a_bits_data,
  input  logic                in1_a_bits_corrupt,
  output logic                in0_d_valid,
  input  logic                in0_d_ready,
  output logic [2:0]          in0_d_bits_opcode,
  output logic [1:0]          in0_d_bits_param,
  output logic [2:0]          in0_d_bits_size,
  output logic [SRC_W-1:0]    in0_d_bits_source,
  output logic                in0_d_bits_sink,
  output logic                in0_d_bits_denied,
  output logic [DATA_W-1:0]   in0_d_bits_data,
  output logic                in0_d_bits_corrupt,
  output logic                in1_d_valid,
  input  logic                in1_d_ready,
  output logic [2:0]          in1_d_bits_opcode,
  output logic [1:0]          in1_d_bits_param,
  output logic [2:0]          in1_d_bits_size,
  output logic [SRC_W-1:0]    in1_d_bits_source,
  output logic                in1_d_bits_sink,
  output logic                in1_d_bits_denied,
  output logic [DATA_W-1:0]   in1_d_bits_data,
  output logic                in1_d_bits_corrupt,
  output logic                out_a_valid,
  input  logic                out_a_ready,
  output logic [2:0]          out_a_bits_opcode,
  output logic [2:0]          out_a_bits_param,
  output logic [2:0]          out_a_bits_size,
  output logic [SRC_W:0]      out_a_bits_source,
  output logic [ADDR_W-1:0]   out_a_bits_address,
  output logic [DATA_W/8-1:0] out_a_bits_mask,
  output logic [DATA_W-1:0]   out_a_bits_data,
  output logic                out_a_bits_corrupt,
  input  logic                out_d_valid,
  output logic                out_d_ready,
  input  logic [2:0]          out_d_bits_opcode,
  input  logic [1:0]          out_d_bits_param,
  input  logic [2:0]          out_d_bits_size,
  input  logic [SRC_W:0]      out_d_bits_source,
  input  logic                out_d_bits_sink,
  input  logic                out_d_bits_denied,
  input  logic [DATA_W-1:0]   out_d_bits_data,
  input  logic                out_d_bits_corrupt
);

  localparam int BW = MAX_SIZE - 3;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] HOLD  = 2'd1;
  localparam logic [1:0] BURST = 2'd2;

  logic [1:0]    state_reg, state_next;
  logic          owner_reg, owner_next;
  logic          rr_ptr_reg, rr_ptr_next;
  logic [BW-1:0] beats_left_reg, beats_left_next;

  logic          grant;
  logic          a_fire;
  logic          multi_beat;
  logic [2:0]    eff_size;
  logic [BW:0]   beat_cnt;
  logic [BW:0]   beat_cnt_m1;

  // In IDLE the grant is decided combinationally; once stalled or bursting it is pinned to owner.
  always_comb begin
    grant = 1'b0;
    if (state_reg == IDLE) begin
      if (in0_a_valid && in1_a_valid) grant = rr_ptr_reg;
      else if (in1_a_valid)           grant = 1'b1;
      else                            grant = 1'b0;
    end else begin
      grant = owner_reg;
    end
  end

  assign out_a_valid        = grant ? in1_a_valid : in0_a_valid;
  assign in0_a_ready        = out_a_ready & ~grant;
  assign in1_a_ready        = out_a_ready &  grant;
  assign out_a_bits_opcode  = grant ? in1_a_bits_opcode  : in0_a_bits_opcode;
  assign out_a_bits_param   = grant ? in1_a_bits_param   : in0_a_bits_param;
  assign out_a_bits_size    = grant ? in1_a_bits_size    : in0_a_bits_size;
  assign out_a_bits_source  = grant ? {1'b1, in1_a_bits_source} : {1'b0, in0_a_bits_source};
  assign out_a_bits_address = grant ? in1_a_bits_address : in0_a_bits_address;
  assign out_a_bits_mask    = grant ? in1_a_bits_mask    : in0_a_bits_mask;
  assign out_a_bits_data    = grant ? in1_a_bits_data    : in0_a_bits_data;
  assign out_a_bits_corrupt = grant ? in1_a_bits_corrupt : in0_a_bits_corrupt;

  assign a_fire = out_a_valid & out_a_ready;

  // Only Put messages carry data on A; Gets larger than a beat stay single-beat here.
  assign multi_beat  = (out_a_bits_opcode == 3'd0 || out_a_bits_opcode == 3'd1) &&
                       (out_a_bits_size > 3'd3);
  assign eff_size    = (out_a_bits_size > 3'(MAX_SIZE)) ? 3'(MAX_SIZE) : out_a_bits_size;
  assign beat_cnt    = (BW+1)'(1) << (eff_size - 3'd3);
  assign beat_cnt_m1 = beat_cnt - (BW+1)'(1);

  always_comb begin
    state_next      = state_reg;
    owner_next      = owner_reg;
    rr_ptr_next     = rr_ptr_reg;
    beats_left_next = beats_left_reg;
    case (state_reg)
      IDLE, HOLD: begin
        if (a_fire) begin
          if (multi_beat) begin
            state_next      = BURST;
            owner_next      = grant;
            beats_left_next = beat_cnt_m1[BW-1:0];
          end else begin
            state_next  = IDLE;
            rr_ptr_next = ~grant;
          end
        end else if (state_reg == IDLE && out_a_valid) begin
          state_next = HOLD;
          owner_next = grant;
        end
      end
      BURST: begin
        if (a_fire) begin
          beats_left_next = beats_left_reg - BW'(1);
          if (beats_left_reg == BW'(1)) begin
            state_next  = IDLE;
            rr_ptr_next = ~owner_reg;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= IDLE;
      owner_reg      <= 1'b0;
      rr_ptr_reg     <= 1'b0;
      beats_left_reg <= '0;
    end else begin
      state_reg      <= state_next;
      owner_reg      <= owner_next;
      rr_ptr_reg     <= rr_ptr_next;
      beats_left_reg <= beats_left_next;
    end
  end

  // D channel is stateless: the extra source MSB selects the client.
  logic d_sel;
  assign d_sel       = out_d_bits_source[SRC_W];
  assign in0_d_valid = out_d_valid & ~d_sel;
  assign in1_d_valid = out_d_valid &  d_sel;
  assign out_d_ready = d_sel ? in1_d_ready : in0_d_ready;

  assign in0_d_bits_opcode  = out_d_bits_opcode;
  assign in0_d_bits_param   = out_d_bits_param;
  assign in0_d_bits_size    = out_d_bits_size;
  assign in0_d_bits_source  = out_d_bits_source[SRC_W-1:0];
  assign in0_d_bits_sink    = out_d_bits_sink;
  assign in0_d_bits_denied  = out_d_bits_denied;
  assign in0_d_bits_data    = out_d_bits_data;
  assign in0_d_bits_corrupt = out_d_bits_corrupt;
  assign in1_d_bits_opcode  = out_d_bits_opcode;
  assign in1_d_bits_param   = out_d_bits_param;
  assign in1_d_bits_size    = out_d_bits_size;
  assign in1_d_bits_source  = out_d_bits_source[SRC_W-1:0];
  assign in1_d_bits_sink    = out_d_bits_sink;
  assign in1_d_bits_denied  = out_d_bits_denied;
  assign in1_d_bits_data    = out_d_bits_data;
  assign in1_d_bits_corrupt = out_d_bits_corrupt;

`ifdef TL_ARB_PERF_EN
  logic [31:0] grant_cnt0_reg, grant_cnt1_reg, conflict_cnt_reg;
  logic        first_fire;
  assign first_fire = a_fire && (state_reg != BURST);

  always_ff @(posedge clock) begin
    if (reset) begin
      grant_cnt0_reg   <= '0;
      grant_cnt1_reg   <= '0;
      conflict_cnt_reg <= '0;
    end else begin
      if (first_fire && !grant) grant_cnt0_reg <= grant_cnt0_reg + 32'd1;
      if (first_fire &&  grant) grant_cnt1_reg <= grant_cnt1_reg + 32'd1;
      // With both requesting, one of them is necessarily waiting.
      if (in0_a_valid && in1_a_valid) conflict_cnt_reg <= conflict_cnt_reg + 32'd1;
    end
  end

  assign grant_cnt0   = grant_cnt0_reg;
  assign grant_cnt1   = grant_cnt1_reg;
  assign conflict_cnt = conflict_cnt_reg;
`endif

endmodule
